// File: rtl/types_pkg.sv
// Shared types for the iterative multiply/divide unit.
package types_pkg;
   localparam int XLEN = 32;

   typedef enum logic [1:0] {
      OP_MULTU = 2'b00,
      OP_MULT  = 2'b01,
      OP_DIVU  = 2'b10,
      OP_DIV   = 2'b11
   } md_op_t;

   typedef enum logic [1:0] {
      MD_IDLE,
      MD_RUN,
      MD_FIX
   } md_state_t;
endpackage

// File: rtl/md_iter_core.sv
// Unsigned iteration datapath: one shift-add multiply or restoring
// shift-subtract divide step per enabled cycle on a 2*XLEN working register.
module md_iter_core #(
   parameter int XLEN = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              step,
   input  logic              is_div,
   input  logic [XLEN-1:0]   a,
   input  logic [XLEN-1:0]   b,
   output logic [2*XLEN-1:0] acc
);
   logic [XLEN-1:0] b_q;
   logic [XLEN:0]   add_sum;
   logic [XLEN:0]   rem_sh;
   logic [XLEN:0]   sub_diff;

   // Multiply keeps the multiplier in the low half and shifts right;
   // divide keeps {remainder, quotient} and shifts left.
   always_comb begin
      add_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, b_q};
      rem_sh   = acc[2*XLEN-1:XLEN-1];
      sub_diff = rem_sh - {1'b0, b_q};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc <= '0;
         b_q <= '0;
      end else if (load) begin
         acc <= {{XLEN{1'b0}}, a};
         b_q <= b;
      end else if (step) begin
         if (is_div) begin
            // Top bit of the difference is the borrow: restore on borrow.
            if (!sub_diff[XLEN])
               acc <= {sub_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            else
               acc <= {acc[2*XLEN-2:0], 1'b0};
         end else begin
            if (acc[0])
               acc <= {add_sum, acc[XLEN-1:1]};
            else
               acc <= {1'b0, acc[2*XLEN-1:1]};
         end
      end
   end
endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers.
// Signed operation support is built only when MUL_DIV_SIGNED_EN is defined.
module mul_div_unit
   import types_pkg::*;
#(
   parameter int XLEN = types_pkg::XLEN
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  md_op_t          op,
   input  logic [XLEN-1:0] operand_a,
   input  logic [XLEN-1:0] operand_b,
   input  logic            hi_we,
   input  logic            lo_we,
   output logic            busy,
   output logic            done,
   output logic            div_by_zero,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo
);
   localparam int CW = $clog2(XLEN);

   md_state_t        state_q, state_d;
   logic [CW-1:0]    count_q;
   logic             is_div_q, div0_q;
   logic             load, step, fix;
   logic             start_div;
   logic [2*XLEN-1:0] acc;
   logic [XLEN-1:0]  a_mag, b_mag, hi_fix, lo_fix;

   assign start_div = (op == OP_DIVU) || (op == OP_DIV);
   assign busy      = (state_q != MD_IDLE);

`ifdef MUL_DIV_SIGNED_EN
   logic op_signed, neg_q_q, neg_r_q;
   assign op_signed = (op == OP_MULT) || (op == OP_DIV);
   assign a_mag = (op_signed && operand_a[XLEN-1]) ? -operand_a : operand_a;
   assign b_mag = (op_signed && operand_b[XLEN-1]) ? -operand_b : operand_b;
`else
   assign a_mag = operand_a;
   assign b_mag = operand_b;
`endif

   md_iter_core #(.XLEN(XLEN)) u_core (
      .clk    (clk),
      .rst    (rst),
      .load   (load),
      .step   (step),
      .is_div (is_div_q),
      .a      (a_mag),
      .b      (b_mag),
      .acc    (acc)
   );

   always_comb begin
      hi_fix = acc[2*XLEN-1:XLEN];
      lo_fix = acc[XLEN-1:0];
`ifdef MUL_DIV_SIGNED_EN
      if (is_div_q) begin
         if (neg_q_q) lo_fix = -acc[XLEN-1:0];
         if (neg_r_q) hi_fix = -acc[2*XLEN-1:XLEN];
      end else if (neg_q_q) begin
         {hi_fix, lo_fix} = -acc;
      end
`endif
      // Remainder already equals the dividend here; only the quotient is forced.
      if (div0_q) lo_fix = '1;
   end

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      step    = 1'b0;
      fix     = 1'b0;
      case (state_q)
         MD_IDLE: if (start) begin
            load    = 1'b1;
            state_d = MD_RUN;
         end
         MD_RUN: begin
            step = 1'b1;
            if (count_q == CW'(XLEN-1)) state_d = MD_FIX;
         end
         MD_FIX: begin
            fix     = 1'b1;
            state_d = MD_IDLE;
         end
         default: state_d = MD_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= MD_IDLE;
         count_q     <= '0;
         is_div_q    <= 1'b0;
         div0_q      <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         hi          <= '0;
         lo          <= '0;
`ifdef MUL_DIV_SIGNED_EN
         neg_q_q     <= 1'b0;
         neg_r_q     <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         done        <= fix;
         div_by_zero <= fix & div0_q;
         if (load) begin
            count_q  <= '0;
            is_div_q <= start_div;
            div0_q   <= start_div && (operand_b == '0);
`ifdef MUL_DIV_SIGNED_EN
            neg_q_q  <= op_signed && (operand_a[XLEN-1] ^ operand_b[XLEN-1]);
            neg_r_q  <= op_signed && operand_a[XLEN-1];
`endif
         end else if (step) begin
            count_q <= count_q + 1'b1;
         end
         if (fix) begin
            hi <= hi_fix;
            lo <= lo_fix;
         end else if (state_q == MD_IDLE && !start) begin
            if (hi_we) hi <= operand_a;
            if (lo_we) lo <= operand_a;
         end
      end
   end
endmodule
